// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_arbiter
//  Purpose  : Shares one single-port BRAM (posedge write, negedge registered
//             read) between two requesters. Port 0 is the pipeline memory
//             stage, port 1 is the debug unit (load/dump). At most one access
//             is accepted per cycle. The winner's command is registered onto
//             the BRAM pins, and read data returns to the winning port with a
//             one-cycle valid pulse two cycles after the grant.
//
//  Configuration macro: BRAM_ARB_RR_EN
//    defined     : strict round-robin on simultaneous requests
//    not defined : fixed priority to port 0, with a MAX_BURST starvation limit
//
//  Parameters
//    ADDRESS_BITS  BRAM address width
//    DATA_BITS     BRAM data width
//    MAX_BURST     consecutive port-0 grants allowed while port 1 waits (>=1)
//
//  Ports
//    clk            system clock, all logic on posedge
//    rst            synchronous reset, active low
//    i_req0/1       access request; held with its command until granted
//    i_we0/1        1 = write, 0 = read
//    i_addr0/1      access address
//    i_wdata0/1     write data
//    o_gnt0/1       request accepted this cycle (combinational)
//    o_rvalid0/1    read data valid, one-cycle pulse
//    o_rdata0/1     read data, holds last value while o_rvalidX = 0
//    o_bram_we      BRAM write enable (registered)
//    o_bram_addr    BRAM address (registered)
//    o_bram_wdata   BRAM write data (registered)
//    i_bram_rdata   BRAM read data
//
//  Revision : 1.0  initial release
// ============================================================================
module bram_arbiter #(
  parameter int ADDRESS_BITS = 8,
  parameter int DATA_BITS    = 32,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_req0,
  input  logic                    i_we0,
  input  logic [ADDRESS_BITS-1:0] i_addr0,
  input  logic [DATA_BITS-1:0]    i_wdata0,
  output logic                    o_gnt0,
  output logic                    o_rvalid0,
  output logic [DATA_BITS-1:0]    o_rdata0,

  input  logic                    i_req1,
  input  logic                    i_we1,
  input  logic [ADDRESS_BITS-1:0] i_addr1,
  input  logic [DATA_BITS-1:0]    i_wdata1,
  output logic                    o_gnt1,
  output logic                    o_rvalid1,
  output logic [DATA_BITS-1:0]    o_rdata1,

  output logic                    o_bram_we,
  output logic [ADDRESS_BITS-1:0] o_bram_addr,
  output logic [DATA_BITS-1:0]    o_bram_wdata,
  input  logic [DATA_BITS-1:0]    i_bram_rdata
);

  localparam int                  CNT_BITS    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0] C_MAX_BURST = CNT_BITS'(MAX_BURST);
  localparam logic [CNT_BITS-1:0] C_CNT_ONE   = CNT_BITS'(1);

  // State records the last winner; S_IDLE means no grant last cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P0   = 2'd1,
    S_P1   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_BITS-1:0]     burst_cnt_q, burst_cnt_d;

  logic                    gnt0;
  logic                    gnt1;

  // Stage 1: command registered onto the BRAM pins.
  logic                    bram_we_q, bram_we_d;
  logic [ADDRESS_BITS-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_BITS-1:0]    bram_wdata_q, bram_wdata_d;
  // Which port owns the read currently at the BRAM.
  logic                    rd_pend0_q, rd_pend0_d;
  logic                    rd_pend1_q, rd_pend1_d;

  // Stage 2: read data returned to the owning port.
  logic                    rvalid0_q, rvalid0_d;
  logic                    rvalid1_q, rvalid1_d;
  logic [DATA_BITS-1:0]    rdata0_q, rdata0_d;
  logic [DATA_BITS-1:0]    rdata1_q, rdata1_d;

  // --------------------------------------------------------------------------
  // Arbitration: grant decode, next state and burst counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;

    // Grants are suppressed while reset is asserted.
    if (rst) begin
`ifdef BRAM_ARB_RR_EN
      // On contention the port that did not win last time goes next; idle
      // counts as "port 1 won last", so port 0 goes first out of idle.
      if (i_req0 && i_req1) begin
        if (state_q == S_P0) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = i_req0;
        gnt1 = i_req1;
      end
      burst_cnt_d = '0;
`else
      // Port 0 wins ties until it has taken MAX_BURST grants in a row while
      // port 1 was waiting; then port 1 is let through once.
      if (i_req1 && (!i_req0 || (burst_cnt_q == C_MAX_BURST))) begin
        gnt1 = 1'b1;
      end else if (i_req0) begin
        gnt0 = 1'b1;
      end

      // With no request at all the count is left alone.
      if (gnt1) begin
        burst_cnt_d = '0;
      end else if (gnt0) begin
        if (i_req1) begin
          burst_cnt_d = (burst_cnt_q == C_MAX_BURST) ? burst_cnt_q
                                                      : burst_cnt_q + C_CNT_ONE;
        end else begin
          burst_cnt_d = '0;
        end
      end
`endif

      if (gnt0) begin
        state_d = S_P0;
      end else if (gnt1) begin
        state_d = S_P1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: command register and read return
  // --------------------------------------------------------------------------
  always_comb begin
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    rd_pend0_d   = 1'b0;
    rd_pend1_d   = 1'b0;

    if (gnt0) begin
      bram_we_d    = i_we0;
      bram_addr_d  = i_addr0;
      bram_wdata_d = i_wdata0;
      rd_pend0_d   = ~i_we0;
    end else if (gnt1) begin
      bram_we_d    = i_we1;
      bram_addr_d  = i_addr1;
      bram_wdata_d = i_wdata1;
      rd_pend1_d   = ~i_we1;
    end

    // The BRAM presents data after the negedge of the cycle the read sits on
    // its pins, so it is captured at the following posedge.
    rvalid0_d = rd_pend0_q;
    rvalid1_d = rd_pend1_q;
    rdata0_d  = rd_pend0_q ? i_bram_rdata : rdata0_q;
    rdata1_d  = rd_pend1_q ? i_bram_rdata : rdata1_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      burst_cnt_q  <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      rd_pend0_q   <= 1'b0;
      rd_pend1_q   <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      rd_pend0_q   <= rd_pend0_d;
      rd_pend1_q   <= rd_pend1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign o_gnt0       = gnt0;
  assign o_gnt1       = gnt1;
  assign o_rvalid0    = rvalid0_q;
  assign o_rvalid1    = rvalid1_q;
  assign o_rdata0     = rdata0_q;
  assign o_rdata1     = rdata1_q;
  assign o_bram_we    = bram_we_q;
  assign o_bram_addr  = bram_addr_q;
  assign o_bram_wdata = bram_wdata_q;

endmodule
`default_nettype wire
